// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: free-running 0..CLOCKS_PER_BIT-1 counter with a one-cycle wrap strobe.
module uart_baud_counter #(
  parameter int unsigned CLOCKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned CntWidth = $clog2(CLOCKS_PER_BIT);
  localparam logic [CntWidth-1:0] LastCount = CntWidth'(CLOCKS_PER_BIT - 1);

  if (CLOCKS_PER_BIT < 2) begin : gen_bad_cpb
    $error("uart_baud_counter: CLOCKS_PER_BIT must be at least 2");
  end

  logic [CntWidth-1:0] count_q, count_d;

  assign bit_done = (count_q == LastCount);

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || bit_done) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit.
// Accepts one byte per frame via a ready/valid handshake; serial_out is a flop output.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [UART_DATA_WIDTH-1:0] data_in,
  input  logic                       data_in_valid,
  output logic                       data_in_ready,
  output logic                       serial_out
);

  localparam int unsigned CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned BitIdxWidth    = $clog2(UART_DATA_WIDTH);
  localparam logic [BitIdxWidth-1:0] LastBitIdx = BitIdxWidth'(UART_DATA_WIDTH - 1);

  uart_state_e                state_q, state_d;
  logic [UART_DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BitIdxWidth-1:0]     bit_idx_q, bit_idx_d;
  logic                       serial_out_q, serial_out_d;
  logic                       bit_done;
  logic                       counter_clear;

  // Restart the bit period on every state change so each level lasts a full period.
  assign counter_clear = (state_d != state_q);

  uart_baud_counter #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_baud_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (counter_clear),
    .bit_done(bit_done)
  );

  assign data_in_ready = (state_q == IDLE);
  assign serial_out    = serial_out_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    unique case (state_q)
      IDLE: begin
        if (data_in_valid) begin
          state_d = START;
          shift_d = data_in;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LastBitIdx) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from the next state so it changes together with the state register.
  always_comb begin
    serial_out_d = 1'b1;
    unique case (state_d)
      IDLE:    serial_out_d = 1'b1;
      START:   serial_out_d = 1'b0;
      DATA:    serial_out_d = shift_d[0];
      STOP:    serial_out_d = 1'b1;
      default: serial_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      serial_out_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      serial_out_q <= serial_out_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at 4 clocks per bit: directed frames plus a
// mid-bit sampling receiver model fed with random bytes and gaps.
module tb_uart_transmitter;

  localparam int unsigned Cpb = 4;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sent_q[$];

  uart_transmitter #(
    .CLOCK_FREQ(400),
    .BAUD_RATE (100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line level during frame bit k (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!data_in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!data_in_ready) check_eq("ready_timeout", data_in_ready, 1);
  endtask

  // Send one byte and compare the whole 40-cycle waveform plus a short idle tail.
  task automatic send_frame(input logic [7:0] b, input bit disturb);
    check_eq("pre_ready", data_in_ready, 1);
    data_in       = b;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    for (int i = 0; i < 10 * Cpb; i++) begin
      check_eq("frame_line", serial_out, frame_bit(b, i / Cpb));
      check_eq("frame_busy", data_in_ready, 0);
      if (disturb) begin
        if (i == 10) data_in = 8'($urandom);
        if (i == 20) begin
          data_in       = 8'hFF;
          data_in_valid = 1'b1;
        end
        if (i == 21) data_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      check_eq("tail_ready", data_in_ready, 1);
      check_eq("tail_line", serial_out, 1);
      @(negedge clk);
    end
  endtask

  task automatic run_back_to_back();
    logic [7:0] rx;
    logic       exp_line;
    rx            = '0;
    data_in       = 8'h55;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in = 8'h0F;
    for (int i = 0; i < 81; i++) begin
      if (i < 40) exp_line = frame_bit(8'h55, i / Cpb);
      else if (i == 40) exp_line = 1'b1;
      else exp_line = frame_bit(8'h0F, (i - 41) / Cpb);
      check_eq("b2b_line", serial_out, exp_line);
      check_eq("b2b_ready", data_in_ready, (i == 40) ? 1 : 0);
      if (i >= 45 && i < 77 && ((i - 41) % Cpb) == 2) rx[(i - 41) / Cpb - 1] = serial_out;
      if (i == 41) data_in_valid = 1'b0;
      @(negedge clk);
    end
    check_eq("b2b_second_byte", rx, 8'h0F);
  endtask

  task automatic run_reset_mid_frame();
    data_in       = 8'h81;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    repeat (17) @(negedge clk);
    check_eq("bit3_line", serial_out, 0);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_line", serial_out, 1);
    check_eq("async_rst_ready", data_in_ready, 1);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("post_rst_line", serial_out, 1);
    send_frame(8'h3C, 1'b0);
  endtask

  task automatic rand_driver();
    logic [7:0] b;
    for (int n = 0; n < 256; n++) begin
      wait_ready();
      repeat ($urandom_range(0, 10)) @(negedge clk);
      b             = 8'($urandom);
      data_in       = b;
      data_in_valid = 1'b1;
      sent_q.push_back(b);
      @(negedge clk);
      data_in_valid = 1'b0;
    end
  endtask

  // Receiver model: find the falling start edge, then sample each bit in its middle.
  task automatic rand_monitor();
    logic [7:0] rx;
    logic [7:0] exp_b;
    int         t;
    for (int n = 0; n < 256; n++) begin
      t = 0;
      while (serial_out !== 1'b0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (serial_out !== 1'b0) begin
        check_eq("rx_timeout", serial_out, 0);
        break;
      end
      repeat (Cpb / 2) @(negedge clk);
      check_eq("rx_start", serial_out, 0);
      for (int k = 0; k < 8; k++) begin
        repeat (Cpb) @(negedge clk);
        rx[k] = serial_out;
      end
      repeat (Cpb) @(negedge clk);
      check_eq("rx_stop", serial_out, 1);
      exp_b = (sent_q.size() != 0) ? sent_q.pop_front() : 8'hxx;
      check_eq("rx_byte", rx, exp_b);
    end
  endtask

  initial begin
    reset         = 1'b1;
    data_in       = '0;
    data_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      check_eq("idle_line", serial_out, 1);
      check_eq("idle_ready", data_in_ready, 1);
      @(negedge clk);
    end

    send_frame(8'hA3, 1'b0);
    run_back_to_back();
    wait_ready();
    send_frame(8'h5A, 1'b1);
    run_reset_mid_frame();

    fork
      rand_driver();
      rand_monitor();
    join
    check_eq("rx_all_consumed", sent_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
